// File: rtl/mem_pkg.sv
// Types and constants shared by the mem stage and the data-memory responder.
package mem_pkg;

    localparam int xlen = 32;

    typedef logic [3:0] strobe_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam strobe_t STRB_B0 = 4'b0001;
    localparam strobe_t STRB_B1 = 4'b0010;
    localparam strobe_t STRB_B2 = 4'b0100;
    localparam strobe_t STRB_B3 = 4'b1000;
    localparam strobe_t STRB_H0 = 4'b0011;
    localparam strobe_t STRB_H1 = 4'b0110;
    localparam strobe_t STRB_H2 = 4'b1100;
    localparam strobe_t STRB_W  = 4'b1111;

    // Right-align read data starting at the lowest enabled lane; single-byte
    // reads are zero-extended, wider patterns take 16 bits from that lane up.
    function automatic logic [15:0] format_read(input logic [xlen-1:0] word,
                                                input strobe_t strb);
        logic [1:0]      lane;
        logic [xlen-1:0] shifted;
        logic [15:0]     res;
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (strb[i]) lane = 2'(i);
        end
        shifted = word >> {lane, 3'b000};
        res     = shifted[15:0];
        case (strb)
            4'b0000:                            res = 16'h0000;
            STRB_B0, STRB_B1, STRB_B2, STRB_B3: res[15:8] = 8'h00;
            STRB_H0, STRB_H1, STRB_H2, STRB_W:  res = shifted[15:0];
            default:                            res = shifted[15:0];
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data store with per-byte-lane write enables and an async read port.
module dmem_array
    import mem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   widx,
    input  strobe_t         be,
    input  logic [xlen-1:0] wdata,
    input  logic [AW-1:0]   ridx,
    output logic [xlen-1:0] rdata
);

    logic [3:0][7:0] mem [DEPTH];

    // NOTE: the storage array has no reset; clearing a RAM costs a port-wide
    // write sequence and software never relies on initial contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][i] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the mem-stage load/store handshake: immediate writes, reads
// answered with a one-cycle hit after LATENCY wait states.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            r_v,
    input  logic            w_v,
    input  logic [xlen-1:0] req_adr,
    input  logic [xlen-1:0] req_data,
    input  logic [3:0]      req_strobe,
    output logic            hit,
    output logic [15:0]     mem_res,
    output logic            busy,
    output logic            err,
    input  logic            err_clr
);

    localparam int              AW        = $clog2(DEPTH);
    localparam logic [xlen-1:0] ADR_LIMIT = xlen'(DEPTH * 4);

    dmem_state_t     state, next_state;
    logic [3:0]      cnt, cnt_next;
    logic [AW-1:0]   req_idx, rd_idx, sel_idx;
    strobe_t         rd_strb, sel_strb;
    logic            rd_ok, sel_ok, in_range;
    logic            we, latch_rd, err_set;
    logic [xlen-1:0] rdata;

    assign req_idx  = req_adr[AW+1:2];
    assign in_range = (req_adr < ADR_LIMIT);

    // A zero-latency read goes straight to RESP, so the live request feeds the mux.
    assign sel_idx  = (state == IDLE) ? req_idx    : rd_idx;
    assign sel_strb = (state == IDLE) ? req_strobe : rd_strb;
    assign sel_ok   = (state == IDLE) ? in_range   : rd_ok;

    assign busy = (state != IDLE);

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk  (clk),
        .we   (we),
        .widx (req_idx),
        .be   (req_strobe),
        .wdata(req_data),
        .ridx (sel_idx),
        .rdata(rdata)
    );

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        we         = 1'b0;
        latch_rd   = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                if (r_v && w_v) begin
                    err_set = 1'b1;
                end else if (w_v) begin
                    we      = in_range;
                    err_set = !in_range;
                end else if (r_v) begin
                    latch_rd   = 1'b1;
                    err_set    = !in_range;
                    cnt_next   = 4'(LATENCY);
                    next_state = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                err_set  = w_v;
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) next_state = RESP;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_idx  <= '0;
            rd_strb <= '0;
            rd_ok   <= 1'b0;
            hit     <= 1'b0;
            mem_res <= 16'h0000;
            err     <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            hit   <= (next_state == RESP);
            if (latch_rd) begin
                rd_idx  <= req_idx;
                rd_strb <= req_strobe;
                rd_ok   <= in_range;
            end
            if (next_state == RESP) begin
                mem_res <= sel_ok ? format_read(rdata, sel_strb) : 16'h0000;
            end
            if (err_set)      err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one LATENCY=2 and one LATENCY=0 instance.
module tb_dmem_responder;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst2, rst0;
    logic        r_v, w_v, err_clr, sel;
    logic [31:0] req_adr, req_data;
    logic [3:0]  req_strobe;

    logic        r_v2, w_v2, clr2, r_v0, w_v0, clr0;
    logic        hit2, busy2, err2, hit0, busy0, err0;
    logic [15:0] mem_res2, mem_res0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q2[$];
    exp_t q0[$];

    assign r_v2 = r_v & ~sel;
    assign w_v2 = w_v & ~sel;
    assign clr2 = err_clr & ~sel;
    assign r_v0 = r_v & sel;
    assign w_v0 = w_v & sel;
    assign clr0 = err_clr & sel;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) dut2 (
        .clk(clk), .rst(rst2), .r_v(r_v2), .w_v(w_v2), .req_adr(req_adr),
        .req_data(req_data), .req_strobe(req_strobe), .hit(hit2),
        .mem_res(mem_res2), .busy(busy2), .err(err2), .err_clr(clr2)
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst0), .r_v(r_v0), .w_v(w_v0), .req_adr(req_adr),
        .req_data(req_data), .req_strobe(req_strobe), .hit(hit0),
        .mem_res(mem_res0), .busy(busy0), .err(err0), .err_clr(clr0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        else n_pass++;
    endtask

    // Scoreboard: every hit must match the oldest outstanding expectation in data and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (hit2) begin
            if (q2.size() == 0) check("unexpected_hit_lat2", 32'd1, 32'd0);
            else begin
                e = q2.pop_front();
                check("lat2_data", {16'h0, mem_res2}, {16'h0, e.data});
                check("lat2_cycle", cyc, e.cyc);
            end
        end
        if (hit0) begin
            if (q0.size() == 0) check("unexpected_hit_lat0", 32'd1, 32'd0);
            else begin
                e = q0.pop_front();
                check("lat0_data", {16'h0, mem_res0}, {16'h0, e.data});
                check("lat0_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_write(input logic [31:0] adr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        w_v = 1'b1; req_adr = adr; req_data = data; req_strobe = strb;
        @(negedge clk);
        w_v = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sel ? busy0 : busy2) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sel ? busy0 : busy2) check(tag, 32'd1, 32'd0);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [3:0] strb, input logic [15:0] exp);
        exp_t e;
        @(negedge clk);
        r_v = 1'b1; req_adr = adr; req_strobe = strb;
        e.data = exp;
        e.cyc  = cyc + 1 + (sel ? 0 : 2);
        if (sel) q0.push_back(e); else q2.push_back(e);
        @(negedge clk);
        r_v = 1'b0;
        check("busy_after_accept", {31'd0, sel ? busy0 : busy2}, 32'd1);
        wait_idle("read_timeout");
    endtask

    initial begin
        exp_t e;
        r_v = 0; w_v = 0; err_clr = 0; sel = 0;
        req_adr = 0; req_data = 0; req_strobe = 0;
        rst2 = 1; rst0 = 1;
        repeat (2) @(negedge clk);
        check("rst_hit", {31'd0, hit2}, 32'd0);
        check("rst_busy", {31'd0, busy2}, 32'd0);
        check("rst_err", {31'd0, err2}, 32'd0);
        check("rst_mem_res", {16'h0, mem_res2}, 32'd0);
        check("rst_lat0_outs", {hit0, busy0, err0, mem_res0}, 32'd0);
        rst2 = 0; rst0 = 0;

        // Word write then read-after-write, followed by lane formatting.
        do_write(32'h10, 32'hDEADBEEF, 4'b1111);
        do_read(32'h10, 4'b1111, 16'hBEEF);
        do_read(32'h11, 4'b0010, 16'h00BE);
        do_read(32'h12, 4'b1100, 16'hDEAD);
        do_read(32'h13, 4'b1000, 16'h00DE);
        do_read(32'h10, 4'b0001, 16'h00EF);
        do_read(32'h10, 4'b0110, 16'hADBE);
        do_read(32'h10, 4'b0101, 16'hBEEF);
        do_read(32'h10, 4'b1010, 16'hADBE);
        do_read(32'h10, 4'b0000, 16'h0000);

        do_write(32'h10, 32'h00550000, 4'b0100);
        do_read(32'h10, 4'b1111, 16'hBEEF);
        do_read(32'h10, 4'b1100, 16'hDE55);

        // Back-to-back: second request held through WAIT/RESP, accepted in the following IDLE.
        @(negedge clk);
        r_v = 1; req_adr = 32'h10; req_strobe = 4'b1111;
        e.data = 16'hBEEF; e.cyc = cyc + 3; q2.push_back(e);
        @(negedge clk);
        req_adr = 32'h12; req_strobe = 4'b1100;
        e.data = 16'hDE55; e.cyc = cyc + 6; q2.push_back(e);
        repeat (4) @(negedge clk);
        r_v = 0;
        check("b2b_busy", {31'd0, busy2}, 32'd1);
        wait_idle("b2b_timeout");
        repeat (3) @(negedge clk);
        check("mem_res_hold", {16'h0, mem_res2}, 32'h0000DE55);

        // Range boundary: last in-range word and aliasing out-of-range write.
        do_write(32'hFFC, 32'h0BADCAFE, 4'b1111);
        do_read(32'hFFC, 4'b1100, 16'h0BAD);
        check("err_clean", {31'd0, err2}, 32'd0);
        do_write(32'h0, 32'hCAFEF00D, 4'b1111);
        do_write(32'h1000, 32'h11111111, 4'b1111);
        check("oob_write_err", {31'd0, err2}, 32'd1);
        @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;
        check("err_clr", {31'd0, err2}, 32'd0);
        do_read(32'h0, 4'b1111, 16'hF00D);
        do_read(32'h1000, 4'b1111, 16'h0000);
        check("oob_read_err", {31'd0, err2}, 32'd1);
        @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;

        // Simultaneous r_v/w_v: no write, err set; set wins over same-cycle clear.
        do_write(32'h20, 32'h12345678, 4'b1111);
        @(negedge clk); r_v = 1; w_v = 1; req_adr = 32'h20; req_data = 32'hFFFFFFFF; req_strobe = 4'b1111;
        @(negedge clk); r_v = 0; w_v = 0;
        check("rw_conflict_err", {31'd0, err2}, 32'd1);
        @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;
        check("err_clr2", {31'd0, err2}, 32'd0);
        @(negedge clk); r_v = 1; w_v = 1; err_clr = 1;
        @(negedge clk); r_v = 0; w_v = 0; err_clr = 0;
        check("set_beats_clr", {31'd0, err2}, 32'd1);
        do_read(32'h20, 4'b1111, 16'h5678);
        @(negedge clk); err_clr = 1; @(negedge clk); err_clr = 0;

        // Write during WAIT is ignored and flags err.
        @(negedge clk);
        r_v = 1; req_adr = 32'h20; req_strobe = 4'b1100;
        e.data = 16'h1234; e.cyc = cyc + 3; q2.push_back(e);
        @(negedge clk);
        r_v = 0; w_v = 1; req_data = 32'h0; req_strobe = 4'b1111;
        @(negedge clk);
        w_v = 0;
        check("wait_write_err", {31'd0, err2}, 32'd1);
        wait_idle("wait_write_timeout");
        do_read(32'h20, 4'b1111, 16'h5678);

        // Asynchronous reset during WAIT drops the read.
        @(negedge clk);
        r_v = 1; req_adr = 32'h10; req_strobe = 4'b1111;
        @(negedge clk);
        r_v = 0;
        check("pre_rst_busy", {31'd0, busy2}, 32'd1);
        #2 rst2 = 1;
        #1;
        check("async_rst_busy", {31'd0, busy2}, 32'd0);
        check("async_rst_err", {31'd0, err2}, 32'd0);
        @(negedge clk); rst2 = 0;
        repeat (6) @(negedge clk);
        check("no_hit_after_rst", {31'd0, hit2}, 32'd0);

        // Zero-latency instance: hit the cycle after acceptance.
        sel = 1;
        do_write(32'h40, 32'hA5A51234, 4'b1111);
        do_read(32'h40, 4'b0011, 16'h1234);
        do_read(32'h41, 4'b0010, 16'h0012);
        do_read(32'h42, 4'b1100, 16'hA5A5);
        do_read(32'h2000, 4'b1111, 16'h0000);
        check("lat0_oob_err", {31'd0, err0}, 32'd1);

        repeat (4) @(negedge clk);
        check("lat2_all_hits_seen", q2.size(), 32'd0);
        check("lat0_all_hits_seen", q0.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
